// File: rtl/axilrdarb.sv
// ---------------------------------------------------------------------------
// axilrdarb -- AXI4-lite read-channel arbiter
//
// Shares one AXI4-lite read port among NS read requesters. AR requests are
// granted round-robin and issued through a registered AR stage. An owner FIFO
// records the requester index of every issued read so that in-order R beats
// are routed back without IDs, allowing up to 2^LGFIFO reads in flight.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN  clock, asynchronous active-low reset
//   S_AXIL_AR*                 NS packed requester AR channels (in)
//   S_AXIL_R*                  NS packed requester R channels (out)
//   M_AXIL_AR*                 shared registered AR channel (out)
//   M_AXIL_R*                  shared R channel (in)
// ---------------------------------------------------------------------------
module axilrdarb #(
    parameter int NS           = 2,
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int LGFIFO       = 4,
    parameter bit OPT_LOWPOWER = 1'b1
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESETN,
    input  logic [NS-1:0]      S_AXIL_ARVALID,
    output logic [NS-1:0]      S_AXIL_ARREADY,
    input  logic [NS*AW-1:0]   S_AXIL_ARADDR,
    input  logic [NS*3-1:0]    S_AXIL_ARPROT,
    output logic [NS-1:0]      S_AXIL_RVALID,
    input  logic [NS-1:0]      S_AXIL_RREADY,
    output logic [NS*DW-1:0]   S_AXIL_RDATA,
    output logic [NS*2-1:0]    S_AXIL_RRESP,
    output logic               M_AXIL_ARVALID,
    input  logic               M_AXIL_ARREADY,
    output logic [AW-1:0]      M_AXIL_ARADDR,
    output logic [2:0]         M_AXIL_ARPROT,
    input  logic               M_AXIL_RVALID,
    output logic               M_AXIL_RREADY,
    input  logic [DW-1:0]      M_AXIL_RDATA,
    input  logic [1:0]         M_AXIL_RRESP
);

    localparam int LGNS  = (NS > 1) ? $clog2(NS) : 1;
    localparam int DEPTH = 1 << LGFIFO;

    // AR output stage
    logic              r_mvalid;
    logic [AW-1:0]     r_maddr;
    logic [2:0]        r_mprot;
    logic [LGNS-1:0]   r_last_grant;

    // Owner FIFO
    logic [LGNS-1:0]   r_owner [DEPTH];
    logic [LGFIFO-1:0] r_wptr;
    logic [LGFIFO-1:0] r_rptr;
    logic [LGFIFO:0]   r_count;

    logic [LGNS-1:0]   w_grant;
    logic [LGNS-1:0]   w_scan;
    logic              w_any;
    logic              w_full;
    logic              w_empty;
    logic              w_can_load;
    logic              w_push;
    logic              w_pop;
    logic [LGNS-1:0]   w_head;

    assign w_full  = (r_count == (LGFIFO+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_owner[r_rptr];

    // Reset gates the accept path so no requester sees ARREADY while in reset.
    assign w_can_load = S_AXI_ARESETN && (!r_mvalid || M_AXIL_ARREADY) && !w_full;
    assign w_push     = w_any && w_can_load;

    // Round-robin scan starting one past the last grant.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_scan  = '0;
        for (int unsigned k = 1; k <= NS; k++) begin
            w_scan = LGNS'((32'(r_last_grant) + k) % NS);
            if (!w_any && S_AXIL_ARVALID[w_scan]) begin
                w_grant = w_scan;
                w_any   = 1'b1;
            end
        end
    end

    always_comb begin
        S_AXIL_ARREADY = '0;
        if (w_push)
            S_AXIL_ARREADY[w_grant] = 1'b1;
    end

    // Registered AR stage: reloads whenever the held request is gone or
    // leaving this cycle, which gives back-to-back issue.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_mvalid     <= 1'b0;
            r_maddr      <= '0;
            r_mprot      <= '0;
            r_last_grant <= LGNS'(NS - 1);
        end else begin
            if (w_push)
                r_last_grant <= w_grant;
            if (!r_mvalid || M_AXIL_ARREADY) begin
                r_mvalid <= w_push;
                if (w_push) begin
                    r_maddr <= S_AXIL_ARADDR[w_grant*AW +: AW];
                    r_mprot <= S_AXIL_ARPROT[w_grant*3 +: 3];
                end else if (OPT_LOWPOWER) begin
                    r_maddr <= '0;
                    r_mprot <= '0;
                end
            end
        end
    end

    assign M_AXIL_ARVALID = r_mvalid;
    assign M_AXIL_ARADDR  = r_maddr;
    assign M_AXIL_ARPROT  = r_mprot;

    // Owner FIFO bookkeeping; count covers the held AR as well as reads
    // already passed downstream.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (w_push)
            r_owner[r_wptr] <= w_grant;
    end

    // R routing: a beat with no recorded owner is never acknowledged.
    assign M_AXIL_RREADY = !w_empty && S_AXIL_RREADY[w_head];
    assign w_pop         = M_AXIL_RVALID && M_AXIL_RREADY;

    always_comb begin
        S_AXIL_RVALID = '0;
        S_AXIL_RDATA  = '0;
        S_AXIL_RRESP  = '0;
        if (!OPT_LOWPOWER) begin
            for (int unsigned i = 0; i < NS; i++) begin
                S_AXIL_RDATA[i*DW +: DW] = M_AXIL_RDATA;
                S_AXIL_RRESP[i*2 +: 2]   = M_AXIL_RRESP;
            end
        end
        if (M_AXIL_RVALID && !w_empty) begin
            S_AXIL_RVALID[w_head] = 1'b1;
            if (OPT_LOWPOWER) begin
                S_AXIL_RDATA[w_head*DW +: DW] = M_AXIL_RDATA;
                S_AXIL_RRESP[w_head*2 +: 2]   = M_AXIL_RRESP;
            end
        end
    end

endmodule

// File: tb/tb_axilrdarb.sv
// ---------------------------------------------------------------------------
// tb_axilrdarb -- randomized self-checking bench for axilrdarb
//
// Requesters, a downstream slave and a queue-based reference model live in
// the bench. Every cycle the DUT outputs are compared against the model.
// ---------------------------------------------------------------------------
module tb_axilrdarb;

    localparam int NS     = 3;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int LGFIFO = 2;
    localparam int CAP    = 1 << LGFIFO;

    logic              clk;
    logic              rst_n;
    logic [NS-1:0]     s_arvalid;
    logic [NS-1:0]     s_arready;
    logic [NS*AW-1:0]  s_araddr;
    logic [NS*3-1:0]   s_arprot;
    logic [NS-1:0]     s_rvalid;
    logic [NS-1:0]     s_rready;
    logic [NS*DW-1:0]  s_rdata;
    logic [NS*2-1:0]   s_rresp;
    logic              m_arvalid;
    logic              m_arready;
    logic [AW-1:0]     m_araddr;
    logic [2:0]        m_arprot;
    logic              m_rvalid;
    logic              m_rready;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;

    axilrdarb #(
        .NS(NS), .AW(AW), .DW(DW), .LGFIFO(LGFIFO), .OPT_LOWPOWER(1'b1)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXIL_ARVALID(s_arvalid),
        .S_AXIL_ARREADY(s_arready),
        .S_AXIL_ARADDR(s_araddr),
        .S_AXIL_ARPROT(s_arprot),
        .S_AXIL_RVALID(s_rvalid),
        .S_AXIL_RREADY(s_rready),
        .S_AXIL_RDATA(s_rdata),
        .S_AXIL_RRESP(s_rresp),
        .M_AXIL_ARVALID(m_arvalid),
        .M_AXIL_ARREADY(m_arready),
        .M_AXIL_ARADDR(m_araddr),
        .M_AXIL_ARPROT(m_arprot),
        .M_AXIL_RVALID(m_rvalid),
        .M_AXIL_RREADY(m_rready),
        .M_AXIL_RDATA(m_rdata),
        .M_AXIL_RRESP(m_rresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    endtask

    // Reference model: held AR, owner order, last grant
    int          md_last;
    bit          md_mvalid;
    logic [31:0] md_maddr;
    logic [2:0]  md_mprot;
    int          md_own[$];

    // Requester stimulus state
    bit          rq_v [NS];
    logic [31:0] rq_a [NS];
    logic [2:0]  rq_p [NS];

    // Downstream slave: addresses it has accepted, plus the beat it holds
    logic [31:0] ds_a[$];
    bit          ds_rv;
    logic [31:0] ds_d;
    logic [1:0]  ds_r;

    task automatic model_clear();
        md_last   = NS - 1;
        md_mvalid = 1'b0;
        md_maddr  = '0;
        md_mprot  = '0;
        md_own.delete();
        ds_a.delete();
        ds_rv = 1'b0;
        for (int i = 0; i < NS; i++) rq_v[i] = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            s_arvalid[i]        = rq_v[i];
            s_araddr[i*AW +: AW] = rq_a[i];
            s_arprot[i*3 +: 3]   = rq_p[i];
        end
        m_rvalid = ds_rv;
        m_rdata  = ds_rv ? ds_d : $urandom;
        m_rresp  = ds_rv ? ds_r : 2'($urandom_range(3));
    endtask

    task automatic step(input int p_req, input int p_ar, input int p_r, input int p_rr);
        int          g;
        int          head;
        bit          can_load;
        bit          nonempty;
        bit          push;
        bit          pop;
        bit          ar_hs;
        bit          e_mrr;
        logic [NS-1:0] e_ar;
        logic [NS-1:0] e_rv;
        logic [31:0] tmp;
        logic [31:0] e_d;
        logic [1:0]  e_r;

        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
            if (!rq_v[i] && $urandom_range(99) < p_req) begin
                rq_v[i] = 1'b1;
                rq_a[i] = $urandom;
                rq_p[i] = 3'($urandom_range(7));
            end
        end
        if (!ds_rv && ds_a.size() > 0 && $urandom_range(99) < p_r) begin
            tmp   = ds_a[0];
            ds_rv = 1'b1;
            ds_d  = tmp ^ 32'h5A5A_0F0F;
            ds_r  = tmp[3:2];
        end
        drive();
        m_arready = ($urandom_range(99) < p_ar);
        for (int i = 0; i < NS; i++) s_rready[i] = ($urandom_range(99) < p_rr);
        #1;

        // Expected outputs from model state and current inputs
        can_load = (!md_mvalid || m_arready) && (md_own.size() < CAP);
        g = -1;
        for (int k = 1; k <= NS; k++) begin
            int idx;
            idx = (md_last + k) % NS;
            if (g < 0 && rq_v[idx]) g = idx;
        end
        push = (g >= 0) && can_load;
        e_ar = '0;
        if (push) e_ar[g] = 1'b1;
        nonempty = (md_own.size() > 0);
        head     = nonempty ? md_own[0] : 0;
        e_mrr    = nonempty && s_rready[head];
        e_rv     = '0;
        if (m_rvalid && nonempty) e_rv[head] = 1'b1;

        check("s_arready", 64'(s_arready), 64'(e_ar));
        check("m_arvalid", 64'(m_arvalid), 64'(md_mvalid));
        check("m_araddr",  64'(m_araddr),  64'(md_maddr));
        check("m_arprot",  64'(m_arprot),  64'(md_mprot));
        check("m_rready",  64'(m_rready),  64'(e_mrr));
        check("s_rvalid",  64'(s_rvalid),  64'(e_rv));
        for (int i = 0; i < NS; i++) begin
            e_d = (e_rv[i]) ? m_rdata : 32'h0;
            e_r = (e_rv[i]) ? m_rresp : 2'b00;
            check($sformatf("s_rdata[%0d]", i), 64'(s_rdata[i*DW +: DW]), 64'(e_d));
            check($sformatf("s_rresp[%0d]", i), 64'(s_rresp[i*2 +: 2]),  64'(e_r));
        end

        pop   = m_rvalid && e_mrr;
        ar_hs = md_mvalid && m_arready;

        @(posedge clk);
        if (ar_hs) ds_a.push_back(md_maddr);
        if (pop) begin
            void'(md_own.pop_front());
            void'(ds_a.pop_front());
            ds_rv = 1'b0;
        end
        if (push) begin
            md_own.push_back(g);
            md_last = g;
            rq_v[g] = 1'b0;
        end
        if (!md_mvalid || m_arready) begin
            md_mvalid = push;
            md_maddr  = push ? rq_a[g] : 32'h0;
            md_mprot  = push ? rq_p[g] : 3'h0;
        end
    endtask

    // Asserts reset mid-cycle with every requester asking; nothing may be
    // accepted while reset is low, and req0 wins first after release.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < NS; i++) begin
            rq_v[i] = 1'b1;
            rq_a[i] = $urandom;
            rq_p[i] = 3'($urandom_range(7));
        end
        drive();
        m_arready = 1'b1;
        s_rready  = '1;
        #1;
        check("rst_s_arready", 64'(s_arready), 64'h0);
        check("rst_m_arvalid", 64'(m_arvalid), 64'h0);
        check("rst_m_araddr",  64'(m_araddr),  64'h0);
        check("rst_m_arprot",  64'(m_arprot),  64'h0);
        check("rst_m_rready",  64'(m_rready),  64'h0);
        check("rst_s_rvalid",  64'(s_rvalid),  64'h0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        s_arvalid = '0;
        s_araddr  = '0;
        s_arprot  = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = '0;
        model_clear();

        do_reset();

        // Light traffic, mixed stalls
        repeat (600) step(40, 70, 60, 80);
        // Heavy requests, rare responses: drives the owner FIFO to full
        repeat (400) step(90, 90, 10, 70);
        // Reset with reads outstanding
        do_reset();
        // Downstream AR stalls dominate
        repeat (600) step(80, 30, 80, 60);
        // Full throughput
        repeat (400) step(100, 100, 100, 100);
        // Response backpressure from requesters
        repeat (400) step(70, 80, 90, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axilrdarb.md
Name: axilrdarb

Overview:
- Read-channel arbiter that shares one AXI4-lite read port among NS AXI4-lite read requesters.
- Typical use: several narrow read masters funnelled into the AR/R side of a width upsizer or an interconnect port.
- Arbitration is round-robin. The AR output is registered.
- An owner FIFO records the requester index of each issued read, so in-order R beats are routed back without IDs and multiple reads stay in flight.

Parameters:
NS, 2, number of requesters (2..8)
AW, 32, address width
DW, 32, data width (same on both sides)
LGFIFO, 4, log2 of maximum outstanding reads (owner FIFO depth 2^LGFIFO)
OPT_LOWPOWER, 1, zero idle/unselected data and address buses

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset, asynchronous, active-low
S_AXIL_ARVALID  in  NS  per-requester read request
S_AXIL_ARREADY  out  NS  per-requester accept
S_AXIL_ARADDR  in  NS*AW  packed addresses, requester i at [i*AW +: AW]
S_AXIL_ARPROT  in  NS*3  packed prot
S_AXIL_RVALID  out  NS  per-requester response valid
S_AXIL_RREADY  in  NS  per-requester response ready
S_AXIL_RDATA  out  NS*DW  packed read data
S_AXIL_RRESP  out  NS*2  packed read response
M_AXIL_ARVALID  out  1  shared read request
M_AXIL_ARREADY  in  1  downstream accept
M_AXIL_ARADDR  out  AW  registered address
M_AXIL_ARPROT  out  3  registered prot
M_AXIL_RVALID  in  1  downstream response valid
M_AXIL_RREADY  out  1  downstream response ready
M_AXIL_RDATA  in  DW  downstream data
M_AXIL_RRESP  in  2  downstream response

Behaviour:
- Reset (async assert, sync release):
  - M_AXIL_ARVALID=0 and S_AXIL_ARREADY=0; ARADDR/ARPROT=0.
  - Owner FIFO empty, count=0.
  - Last-grant pointer = NS-1, so requester 0 has first priority.
- Reset mid-operation discards all in-flight ownership. Downstream is required to be reset with the same signal.
- can_load = (!M_AXIL_ARVALID || M_AXIL_ARREADY) && (count < 2^LGFIFO).
- Grant selection (combinational):
  - Scan requesters starting at last_grant+1 (mod NS); first one with ARVALID high wins.
  - S_AXIL_ARREADY is one-hot(grant) & can_load, and is zero when no requester is valid.
- On accept (ARVALID[g] && ARREADY[g]):
  - Next cycle M_AXIL_ARVALID=1 and ARADDR/ARPROT = requester g's fields.
  - Push g into the owner FIFO; last_grant <= g.
  - Latency: one cycle from S accept to M_AXIL_ARVALID.
- Holding and back-to-back issue:
  - M_AXIL_ARVALID and its payload hold stable until M_AXIL_ARREADY.
  - A new grant loads in the same cycle the held request is accepted, giving back-to-back issue at full throughput.
- When not loading with ARVALID low: OPT_LOWPOWER=1 clears ARADDR/ARPROT to 0; otherwise they are don't-care.
- count tracks reads accepted from requesters and not yet returned (includes the held AR).
  - push only: +1; pop only: -1; push and pop in the same cycle: unchanged.
- Full (count==2^LGFIFO): all S_AXIL_ARREADY=0.
  - A pop in the same cycle does not enable a push that cycle; the push waits one cycle.
- R routing, fully combinational with no added latency. head = FIFO output index.
  - S_AXIL_RVALID[i] = M_AXIL_RVALID && !empty && head==i.
  - M_AXIL_RREADY = !empty && S_AXIL_RREADY[head].
  - Pop on M_AXIL_RVALID && M_AXIL_RREADY.
- Data routing to S_AXIL_RDATA/RRESP lane i:
  - Always receives M_AXIL_RDATA/RRESP when OPT_LOWPOWER=0.
  - When OPT_LOWPOWER=1, only the head lane carries data; all other lanes are zero, and all lanes are zero while M_AXIL_RVALID is low.
- Empty FIFO with M_AXIL_RVALID=1 is a downstream protocol violation: M_AXIL_RREADY stays 0 and no state changes.
- A requester with outstanding reads may be granted again; its responses return in issue order.
- FIFO pointers wrap modulo 2^LGFIFO; count is LGFIFO+1 bits.

Test Plan:
1. NS=2, only req1: ARADDR=0x100 with ARREADY high -> S_ARREADY=2'b10 in cycle 0; M_ARVALID/ARADDR=0x100 in cycle 1; RDATA=0xCAFE returned -> S_RVALID=2'b10, lane1 data 0xCAFE, lane0 data 0.
2. Both requesters valid continuously, M_ARREADY=1 -> grant sequence 0,1,0,1; M_ARVALID high every cycle after the first.
3. LGFIFO=2, 5 requests with no R returned -> exactly 4 accepted, 5th ARREADY low. One R pop -> 5th accepted the following cycle; count stays at 4.
4. Interleaved issue req0,req1,req0; S_RREADY[1]=0 -> second beat stalls with M_RREADY=0 and head=1. Raising RREADY[1] releases it; third beat routes to req0.
5. M_ARREADY low 3 cycles with a new request pending -> ARADDR stable, no second S accept until the held AR completes; then back-to-back issue.
6. Deassert S_AXI_ARESETN asynchronously with 3 reads outstanding -> M_ARVALID=0 and S_ARREADY=0 immediately. After release, count=0 and the first grant goes to req0.
